// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: opcodes, header constants and framer states shared by the UART packet parser and framer
package uart_pkt_pkg;
    localparam logic [7:0] ECHO_OPCODE = 8'hEC;
    localparam logic [7:0] ADD_OPCODE = 8'h01;
    localparam logic [7:0] MUL_OPCODE = 8'h02;
    localparam logic [7:0] DIV_OPCODE = 8'h03;
    localparam logic [15:0] HDR_BYTES = 16'd4;
    localparam logic [7:0] RESERVED_BYTE = 8'h00;
    typedef enum logic [2:0] {IDLE, HDR_OP, HDR_RSV, HDR_LEN_LSB, HDR_LEN_MSB, PAYLOAD} framer_state_t;
endpackage

// File: rtl/byte_out_reg.sv
// byte_out_reg: single-slot valid/ready byte register that can refill in the same cycle it drains
module byte_out_reg (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       can_load_o
);
    assign can_load_o = !valid_o || ready_i;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o  <= 8'h00;
            valid_o <= 1'b0;
        end else if (load_i) begin
            data_o  <= data_i;
            valid_o <= 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end
endmodule

// File: rtl/packet_framer.sv
// packet_framer: serialises opcode, reserved, 16-bit length and payload bytes into a uart_tx byte stream
module packet_framer
    import uart_pkt_pkg::*;
#(
    parameter logic [15:0] MAX_PAYLOAD = 16'd1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_opcode_i,
    input  logic [15:0] cmd_len_i,
    input  logic [7:0]  pay_data_i,
    input  logic        pay_valid_i,
    output logic        pay_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        pkt_done_o,
    output logic        err_o
);
    if (MAX_PAYLOAD > 16'hFFFB) begin : g_max_check
        $error("MAX_PAYLOAD must not exceed 16'hFFFB");
    end
    framer_state_t state, next;
    logic [15:0] len_q, rem_q;
    logic [7:0] din;
    logic load, can_load, done_d, cmd_hs, too_long, tx_hs;
    assign cmd_ready_o = (state == IDLE) && !rst_i;
    assign busy_o = (state != IDLE) && !rst_i;
    assign cmd_hs = cmd_valid_i && cmd_ready_o;
    assign too_long = cmd_len_i > MAX_PAYLOAD;
    assign tx_hs = tx_valid_o && tx_ready_i;
    // The state names the byte currently held in the output slot
    always_comb begin
        next = state;
        load = 1'b0;
        din = pay_data_i;
        done_d = 1'b0;
        pay_ready_o = 1'b0;
        case (state)
            IDLE: if (cmd_hs && !too_long) begin
                load = 1'b1;
                din = cmd_opcode_i;
                next = HDR_OP;
            end
            HDR_OP: if (can_load) begin
                load = 1'b1;
                din = RESERVED_BYTE;
                next = HDR_RSV;
            end
            HDR_RSV: if (can_load) begin
                load = 1'b1;
                din = len_q[7:0];
                next = HDR_LEN_LSB;
            end
            HDR_LEN_LSB: if (can_load) begin
                load = 1'b1;
                din = len_q[15:8];
                next = HDR_LEN_MSB;
            end
            HDR_LEN_MSB: if (rem_q != 16'd0) begin
                next = PAYLOAD;
            end else if (tx_hs) begin
                next = IDLE;
                done_d = 1'b1;
            end
            PAYLOAD: begin
                pay_ready_o = (rem_q != 16'd0) && can_load && !rst_i;
                load = pay_valid_i && pay_ready_o;
                if (rem_q == 16'd0 && tx_hs) begin
                    next = IDLE;
                    done_d = 1'b1;
                end
            end
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            len_q <= 16'd0;
            rem_q <= 16'd0;
            pkt_done_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            state <= next;
            pkt_done_o <= done_d;
            err_o <= cmd_hs && too_long;
            if (cmd_hs) begin
                len_q <= cmd_len_i + HDR_BYTES;
                rem_q <= cmd_len_i;
            end else if (state == PAYLOAD && load) begin
                rem_q <= rem_q - 16'd1;
            end
        end
    end
    byte_out_reg u_out (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .load_i(load),
        .data_i(din),
        .data_o(tx_data_o),
        .valid_o(tx_valid_o),
        .ready_i(tx_ready_i),
        .can_load_o(can_load)
    );
endmodule
